// File: rtl/uart_frame_scheduler_pkg.sv
// Shared definitions for the UART frame scheduler.
//   state_e         : scheduler FSM states
//   DEF_*           : default framing marker bytes
//   HDR_LEN/TRL_LEN : byte counts of the frame/row headers and of the trailer
package uart_frame_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FHDR,
        ST_RHDR,
        ST_RWAIT,
        ST_RSTART,
        ST_RDATA,
        ST_REND,
        ST_FTAIL
    } state_e;

    localparam logic [7:0] DEF_SYNC0    = 8'hA5;
    localparam logic [7:0] DEF_SYNC1    = 8'h5A;
    localparam logic [7:0] DEF_ROW_MARK = 8'hC3;
    localparam logic [7:0] DEF_END_MARK = 8'hE7;

    localparam logic [1:0] HDR_LEN = 2'd3;
    localparam logic [1:0] TRL_LEN = 2'd1;

endpackage

// File: rtl/uart_frame_scheduler_hdr_byte_seq.sv
// Registered sender of a short (1..3 byte) generated sequence.
// The first byte is loaded on i_start; each accepted byte (o_valid && i_tx_ready)
// advances to the next one. o_data is a register, so it stays stable while
// o_valid is high and the sink is not ready.
//   CLK, RST          : clock, asynchronous active-low reset
//   i_clear           : drop the sequence (abort), wins over everything
//   i_start           : load i_byte0..2 and i_len, raise o_valid next cycle
//   i_len             : number of bytes to send (1..3)
//   i_tx_ready        : sink accepts the byte this cycle
//   o_data / o_valid  : byte to the sink
//   o_done            : the last byte is being accepted this cycle
module uart_frame_scheduler_hdr_byte_seq (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_clear,
    input  logic       i_start,
    input  logic [1:0] i_len,
    input  logic [7:0] i_byte0,
    input  logic [7:0] i_byte1,
    input  logic [7:0] i_byte2,
    input  logic       i_tx_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_done
);

    logic [7:0] data_q, data_d;
    logic [7:0] b1_q, b1_d;
    logic [7:0] b2_q, b2_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] len_q, len_d;
    logic       valid_q, valid_d;
    logic       xfer;
    logic       last;

    assign xfer = valid_q && i_tx_ready;
    assign last = (idx_q == (len_q - 2'd1));

    always_comb begin
        data_d  = data_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        idx_d   = idx_q;
        len_d   = len_q;
        valid_d = valid_q;
        if (i_clear) begin
            valid_d = 1'b0;
            idx_d   = 2'd0;
        end else if (i_start) begin
            data_d  = i_byte0;
            b1_d    = i_byte1;
            b2_d    = i_byte2;
            len_d   = i_len;
            idx_d   = 2'd0;
            valid_d = 1'b1;
        end else if (xfer) begin
            if (last) begin
                valid_d = 1'b0;
            end else begin
                idx_d  = idx_q + 2'd1;
                data_d = (idx_q == 2'd0) ? b1_q : b2_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= 8'h00;
            b1_q    <= 8'h00;
            b2_q    <= 8'h00;
            idx_q   <= 2'd0;
            len_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_done  = xfer && last;

endmodule

// File: rtl/uart_frame_scheduler.sv
// Frame scheduler that shares one UART byte channel between generated framing
// bytes and the RLE compressor payload.
// Stream per frame: Sync0 Sync1 frame_cnt | { RowMark row_hi row_lo payload... } x RowCount | EndMark
//   CLK, RST                         : clock, asynchronous active-low reset
//   i_frame_start                    : vsync pulse, starts a frame from IDLE
//   i_abort                          : return to IDLE immediately
//   i_row_ready                      : a full row is buffered
//   o_cmp_start                      : pulse, compress the current row
//   i_cmp_data/valid/last, o_cmp_ready : compressor byte stream
//   o_tx_data/valid, i_tx_ready      : UART byte channel
//   o_row_idx, o_frame_cnt           : current row, frames completed
//   o_busy, o_frame_done, o_overrun  : status
module uart_frame_scheduler
    import uart_frame_scheduler_pkg::*;
#(
    parameter int         RowCount = 480,
    parameter logic [7:0] Sync0    = DEF_SYNC0,
    parameter logic [7:0] Sync1    = DEF_SYNC1,
    parameter logic [7:0] RowMark  = DEF_ROW_MARK,
    parameter logic [7:0] EndMark  = DEF_END_MARK
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        i_frame_start,
    input  logic        i_abort,
    input  logic        i_row_ready,
    output logic        o_cmp_start,
    input  logic [7:0]  i_cmp_data,
    input  logic        i_cmp_valid,
    input  logic        i_cmp_last,
    output logic        o_cmp_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [15:0] o_row_idx,
    output logic [7:0]  o_frame_cnt,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_overrun
);

    localparam logic [15:0] LastRow = 16'(RowCount - 1);

    state_e      state_q, state_d;
    logic [15:0] row_q, row_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        overrun_q, overrun_d;

    logic        seq_start;
    logic [1:0]  seq_len;
    logic [7:0]  seq_b0, seq_b1, seq_b2;
    logic [7:0]  seq_data;
    logic        seq_valid;
    logic        seq_done;

    logic        cmp_start;
    logic        frame_done;
    logic        busy;

    assign busy = (state_q != ST_IDLE);

    // One sender serves frame header, row header and trailer; the FSM loads it
    // on the transition into the sending state so the first byte is valid on
    // the state's first cycle.
    uart_frame_scheduler_hdr_byte_seq u_hdr_byte_seq (
        .CLK        (CLK),
        .RST        (RST),
        .i_clear    (i_abort),
        .i_start    (seq_start),
        .i_len      (seq_len),
        .i_byte0    (seq_b0),
        .i_byte1    (seq_b1),
        .i_byte2    (seq_b2),
        .i_tx_ready (i_tx_ready),
        .o_data     (seq_data),
        .o_valid    (seq_valid),
        .o_done     (seq_done)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        // Busy includes the FTAIL transfer cycle, so a vsync there is an overrun.
        overrun_d   = overrun_q | (i_frame_start & busy);
        seq_start   = 1'b0;
        seq_len     = HDR_LEN;
        seq_b0      = Sync0;
        seq_b1      = Sync1;
        seq_b2      = frame_cnt_q;
        cmp_start   = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    state_d   = ST_FHDR;
                    row_d     = 16'd0;
                    seq_start = 1'b1;
                end
            end
            ST_FHDR: begin
                if (seq_done) state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (i_row_ready) begin
                    state_d   = ST_RHDR;
                    seq_start = 1'b1;
                    seq_b0    = RowMark;
                    seq_b1    = row_q[15:8];
                    seq_b2    = row_q[7:0];
                end
            end
            ST_RHDR: begin
                if (seq_done) state_d = ST_RSTART;
            end
            ST_RSTART: begin
                cmp_start = 1'b1;
                state_d   = ST_RDATA;
            end
            ST_RDATA: begin
                if (i_cmp_valid && i_tx_ready && i_cmp_last) state_d = ST_REND;
            end
            ST_REND: begin
                if (row_q == LastRow) begin
                    state_d   = ST_FTAIL;
                    seq_start = 1'b1;
                    seq_len   = TRL_LEN;
                    seq_b0    = EndMark;
                end else begin
                    row_d   = row_q + 16'd1;
                    state_d = ST_RWAIT;
                end
            end
            ST_FTAIL: begin
                if (seq_done) begin
                    frame_done  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    row_d       = 16'd0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every event of the same cycle.
        if (i_abort) begin
            state_d     = ST_IDLE;
            row_d       = 16'd0;
            frame_cnt_d = frame_cnt_q;
            seq_start   = 1'b0;
            cmp_start   = 1'b0;
            frame_done  = 1'b0;
        end
    end

    // Byte channel mux: generated bytes from the sender register, payload is
    // a zero-latency passthrough of the compressor handshake.
    always_comb begin
        o_tx_data   = 8'h00;
        o_tx_valid  = 1'b0;
        o_cmp_ready = 1'b0;
        case (state_q)
            ST_FHDR, ST_RHDR, ST_FTAIL: begin
                o_tx_data  = seq_data;
                o_tx_valid = seq_valid;
            end
            ST_RDATA: begin
                o_tx_data   = i_cmp_data;
                o_tx_valid  = i_cmp_valid;
                o_cmp_ready = i_tx_ready;
            end
            default: ;
        endcase
        if (i_abort) begin
            o_tx_valid  = 1'b0;
            o_cmp_ready = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            row_q       <= 16'd0;
            frame_cnt_q <= 8'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_cmp_start  = cmp_start;
    assign o_row_idx    = row_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_busy       = busy;
    assign o_frame_done = frame_done;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler with a two-row frame. The bench plays both the
// compressor (per-row random payload) and the UART sink (random ready), and
// compares the captured UART byte stream against the frame layout built from
// the framing rules.
module tb_uart_frame_scheduler;

    localparam int ROWS = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        i_frame_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_row_ready = 1'b0;
    logic        o_cmp_start;
    logic [7:0]  i_cmp_data = 8'h00;
    logic        i_cmp_valid = 1'b0;
    logic        i_cmp_last = 1'b0;
    logic        o_cmp_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic [15:0] o_row_idx;
    logic [7:0]  o_frame_cnt;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_overrun;

    uart_frame_scheduler #(.RowCount(ROWS)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_frame_start (i_frame_start),
        .i_abort       (i_abort),
        .i_row_ready   (i_row_ready),
        .o_cmp_start   (o_cmp_start),
        .i_cmp_data    (i_cmp_data),
        .i_cmp_valid   (i_cmp_valid),
        .i_cmp_last    (i_cmp_last),
        .o_cmp_ready   (o_cmp_ready),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .i_tx_ready    (i_tx_ready),
        .o_row_idx     (o_row_idx),
        .o_frame_cnt   (o_frame_cnt),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_overrun     (o_overrun)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;

    // stimulus knobs
    int rdy_pct = 100;
    int vld_pct = 100;
    int row_pct = 100;
    bit rdy_pat[$];
    bit fs_now = 0;
    bit fs_mid_pending = 0, fs_mid_fired = 0;
    bit abort_pending = 0, abort_fired = 0;
    bit stall_on_start = 0;
    int rd_stall_cnt = 0;

    // reference model state
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    logic [7:0] pay_all[$];
    int pay_len[ROWS];
    int pay_idx = 0, cmp_row = 0, cmp_rem = 0;
    bit cmp_vld = 0;
    int done_cnt = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic build_frame(input int max_len);
        int len;
        logic [7:0] b;
        pay_all.delete(); exp_q.delete(); got.delete();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(exp_cnt);
        for (int r = 0; r < ROWS; r++) begin
            len = $urandom_range(1, max_len);
            pay_len[r] = len;
            exp_q.push_back(8'hC3);
            exp_q.push_back(8'(r >> 8));
            exp_q.push_back(8'(r));
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                pay_all.push_back(b);
                exp_q.push_back(b);
            end
        end
        exp_q.push_back(8'hE7);
        cmp_row = 0; pay_idx = 0; cmp_rem = 0; cmp_vld = 0; done_cnt = 0;
    endtask

    // One clock: drive at posedge+1, check at the falling edge, return at posedge+1.
    task automatic cycle();
        bit fs_drv, ab_drv;
        fs_drv = fs_now; fs_now = 0;
        if (fs_mid_pending && cmp_row == 1 && cmp_rem == 0 && o_busy === 1'b1) begin
            fs_drv = 1; fs_mid_pending = 0; fs_mid_fired = 1;
        end
        ab_drv = 0;
        if (abort_pending && cmp_rem > 0) begin
            ab_drv = 1; abort_pending = 0; abort_fired = 1;
        end
        i_frame_start = fs_drv;
        i_abort = ab_drv;
        if (rdy_pat.size() > 0) i_tx_ready = rdy_pat.pop_front();
        else i_tx_ready = ($urandom_range(0, 99) < rdy_pct);
        i_row_ready = ($urandom_range(0, 99) < row_pct);
        if (cmp_rem > 0) begin
            if (!cmp_vld && $urandom_range(0, 99) < vld_pct) cmp_vld = 1;
            i_cmp_valid = cmp_vld;
            i_cmp_data = cmp_vld ? pay_all[pay_idx] : 8'($urandom);
            i_cmp_last = cmp_vld && (cmp_rem == 1);
        end else begin
            // junk offered outside a row must never be consumed
            i_cmp_valid = 1'($urandom_range(0, 1));
            i_cmp_data = 8'($urandom);
            i_cmp_last = 1'($urandom_range(0, 1));
        end
        #4;
        if (ab_drv) begin
            n_cmp++;
            if (o_tx_valid !== 1'b0 || o_cmp_ready !== 1'b0 || o_frame_done !== 1'b0 || o_cmp_start !== 1'b0)
                begin n_fail++; $display("FAIL abort_outputs got valid=%b ready=%b done=%b start=%b exp all 0", o_tx_valid, o_cmp_ready, o_frame_done, o_cmp_start); end
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)
                    begin n_fail++; $display("FAIL hold got valid=%b data=%h exp valid=1 data=%h", o_tx_valid, o_tx_data, prev_data); end
            end
            if (cmp_rem > 0) begin
                n_cmp++;
                if (o_tx_valid !== i_cmp_valid || o_cmp_ready !== i_tx_ready || (i_cmp_valid && o_tx_data !== i_cmp_data))
                    begin n_fail++; $display("FAIL passthrough got valid=%b ready=%b data=%h exp valid=%b ready=%b data=%h", o_tx_valid, o_cmp_ready, o_tx_data, i_cmp_valid, i_tx_ready, i_cmp_data); end
                if (i_cmp_valid && !i_tx_ready) rd_stall_cnt++;
            end else begin
                n_cmp++;
                if (o_cmp_ready !== 1'b0)
                    begin n_fail++; $display("FAIL cmp_ready_outside_row got=%b exp=0", o_cmp_ready); end
            end
            if (o_frame_done === 1'b1) begin
                done_cnt++;
                n_cmp++;
                if (!(o_tx_valid === 1'b1 && i_tx_ready && o_tx_data === 8'hE7))
                    begin n_fail++; $display("FAIL frame_done_without_trailer got valid=%b ready=%b data=%h exp 1 1 e7", o_tx_valid, i_tx_ready, o_tx_data); end
            end
            if (o_tx_valid === 1'b1 && i_tx_ready) got.push_back(o_tx_data);
            if (o_cmp_ready === 1'b1 && i_cmp_valid && cmp_rem > 0) begin
                pay_idx++; cmp_rem--; cmp_vld = 0;
            end
            if (o_cmp_start === 1'b1) begin
                n_cmp++;
                if (cmp_rem != 0 || cmp_row >= ROWS) begin
                    n_fail++; $display("FAIL cmp_start_unexpected got row=%0d rem=%0d exp row<%0d rem=0", cmp_row, cmp_rem, ROWS);
                end else begin
                    cmp_rem = pay_len[cmp_row];
                    cmp_row++;
                    if (stall_on_start) begin
                        repeat (5) rdy_pat.push_back(1'b0);
                        stall_on_start = 0;
                        rd_stall_cnt = 0;
                    end
                end
            end
        end
        prev_stall = !ab_drv && o_tx_valid === 1'b1 && !i_tx_ready;
        prev_data = o_tx_data;
        @(posedge CLK); #1;
    endtask

    task automatic run_frame(input int max_len);
        int cyc;
        int bad;
        build_frame(max_len);
        fs_now = 1;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin cycle(); cyc++; end
        n_cmp++;
        if (done_cnt == 0) begin n_fail++; $display("FAIL frame_timeout got cycles=%0d exp frame_done", cyc); end
        repeat (3) cycle();
        n_cmp++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL frame_done_count got=%0d exp=1", done_cnt); end
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stream_length got=%0d exp=%0d", got.size(), exp_q.size());
        end else begin
            bad = -1;
            foreach (got[i]) if (bad < 0 && got[i] !== exp_q[i]) bad = i;
            n_cmp++;
            if (bad >= 0) begin n_fail++; $display("FAIL stream_byte[%0d] got=%h exp=%h", bad, got[bad], exp_q[bad]); end
        end
        exp_cnt = exp_cnt + 8'd1;
        n_cmp++;
        if (o_frame_cnt !== exp_cnt) begin n_fail++; $display("FAIL frame_cnt got=%h exp=%h", o_frame_cnt, exp_cnt); end
        n_cmp++;
        if (o_busy !== 1'b0 || o_row_idx !== 16'd0) begin n_fail++; $display("FAIL idle_after_frame got busy=%b row=%0d exp 0 0", o_busy, o_row_idx); end
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if (o_busy !== 0 || o_tx_valid !== 0 || o_tx_data !== 0 || o_cmp_ready !== 0 || o_cmp_start !== 0 ||
            o_row_idx !== 0 || o_frame_cnt !== 0 || o_frame_done !== 0 || o_overrun !== 0)
            begin n_fail++; $display("FAIL %s got busy=%b v=%b d=%h cr=%b cs=%b row=%0d cnt=%h fd=%b ov=%b exp all 0", tag, o_busy, o_tx_valid, o_tx_data, o_cmp_ready, o_cmp_start, o_row_idx, o_frame_cnt, o_frame_done, o_overrun); end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset_state");
        RST = 1'b1;
        @(posedge CLK); #1;
        check_all_zero("idle_after_release");
        $display("test_reset done compared=%0d mismatched=%0d", n_cmp, n_fail);
    endtask

    task automatic test_basic_frame();
        rdy_pct = 100; vld_pct = 100; row_pct = 100;
        run_frame(2);
        $display("test_basic_frame stream=%0d bytes frame_cnt=%h", got.size(), o_frame_cnt);
    endtask

    task automatic test_ready_toggle();
        rdy_pct = 50; vld_pct = 60; row_pct = 40;
        repeat (4) begin
            rdy_pat.push_back(1'b0); // IDLE cycle
            rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        end
        run_frame(4);
        rdy_pat.delete();
        $display("test_ready_toggle stream=%0d bytes frame_cnt=%h", got.size(), o_frame_cnt);
    endtask

    task automatic test_stall_rdata();
        rdy_pct = 100; vld_pct = 100; row_pct = 100;
        stall_on_start = 1;
        run_frame(3);
        n_cmp++;
        if (rd_stall_cnt != 5) begin n_fail++; $display("FAIL rdata_stall_cycles got=%0d exp=5", rd_stall_cnt); end
        $display("test_stall_rdata stall_cycles=%0d", rd_stall_cnt);
    endtask

    task automatic test_abort();
        int cyc;
        rdy_pct = 70; vld_pct = 70; row_pct = 100;
        build_frame(4);
        fs_now = 1;
        abort_pending = 1; abort_fired = 0;
        cyc = 0;
        while (!abort_fired && cyc < 500) begin cycle(); cyc++; end
        n_cmp++;
        if (!abort_fired) begin n_fail++; $display("FAIL abort_not_reached got cycles=%0d exp abort in row", cyc); end
        cmp_rem = 0; cmp_vld = 0; abort_pending = 0;
        cycle();
        n_cmp++;
        if (o_busy !== 1'b0 || o_row_idx !== 16'd0 || o_tx_valid !== 1'b0 || o_frame_cnt !== exp_cnt)
            begin n_fail++; $display("FAIL after_abort got busy=%b row=%0d valid=%b cnt=%h exp 0 0 0 %h", o_busy, o_row_idx, o_tx_valid, o_frame_cnt, exp_cnt); end
        n_cmp++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL abort_frame_done got=%0d exp=0", done_cnt); end
        run_frame(3);
        $display("test_abort frame_cnt=%h", o_frame_cnt);
    endtask

    task automatic test_overrun();
        n_cmp++;
        if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_before got=%b exp=0", o_overrun); end
        rdy_pct = 80; vld_pct = 80; row_pct = 20;
        fs_mid_pending = 1; fs_mid_fired = 0;
        run_frame(3);
        n_cmp++;
        if (!fs_mid_fired || o_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun got=%b fired=%b exp 1 1", o_overrun, fs_mid_fired); end
        fs_mid_pending = 0;
        repeat (5) cycle();
        n_cmp++;
        if (o_busy !== 1'b0 || o_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky_idle got busy=%b ov=%b exp 0 1", o_busy, o_overrun); end
        $display("test_overrun overrun=%b frame_cnt=%h", o_overrun, o_frame_cnt);
    endtask

    task automatic test_wrap();
        int frames;
        rdy_pct = 100; vld_pct = 100; row_pct = 100;
        frames = 0;
        while (exp_cnt != 8'd0 && frames < 300) begin run_frame(1); frames++; end
        n_cmp++;
        if (o_frame_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt got=%h exp=00", o_frame_cnt); end
        run_frame(2);
        n_cmp++;
        if (got.size() < 3 || got[2] !== 8'h00) begin n_fail++; $display("FAIL wrap_header_cnt got=%h exp=00", (got.size() >= 3) ? got[2] : 8'hxx); end
        $display("test_wrap frames=%0d frame_cnt=%h", frames + 1, o_frame_cnt);
    endtask

    task automatic test_async_reset();
        int cyc;
        rdy_pct = 100; vld_pct = 100; row_pct = 100;
        build_frame(2);
        fs_now = 1;
        cyc = 0;
        while (got.size() < 4 && cyc < 200) begin cycle(); cyc++; end
        n_cmp++;
        if (o_busy !== 1'b1 || got.size() < 4) begin n_fail++; $display("FAIL mid_rhdr got busy=%b bytes=%0d exp 1 4", o_busy, got.size()); end
        #2;
        RST = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge CLK); #1;
        check_all_zero("held_in_reset");
        RST = 1'b1;
        exp_cnt = 8'd0; prev_stall = 0; cmp_rem = 0; cmp_vld = 0;
        run_frame(2);
        $display("test_async_reset frame_cnt=%h", o_frame_cnt);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_ready_toggle();
        test_stall_rdata();
        test_abort();
        test_overrun();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
